trace_fifo: RTL and testbench

TRACE_FIFO -- requirements
Module: trace_fifo

---
 rtl/trace_fifo_pkg.sv | 19 +
 rtl/trace_fifo_mem.sv | 24 ++
 rtl/trace_fifo.sv | 127 ++++++++++++
 tb/tb_trace_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_fifo_pkg.sv
// Shared definitions for the trace FIFO: record layout and issue FSM states.
package trace_fifo_pkg;

  localparam int unsigned REC_W    = 13;
  localparam int unsigned TYPE_BIT = 12;
  localparam int unsigned TAG_MSB  = 11;
  localparam int unsigned TAG_LSB  = 0;

  localparam logic SYS_TYPE = 1'b0;
  localparam logic BR_TYPE  = 1'b1;

  // Issue credit is encoded in the state: StIdle means no credit.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StIssue
  } fsm_state_e;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace FIFO storage: DEPTH x DW, one registered write port, asynchronous read port.
module trace_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 13
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DW-1:0]            rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/trace_fifo.sv
// Trace-record FIFO with a single-credit issue handshake to the LSTM/softmax path.
// Optional macro TRACE_FIFO_DROP_CNT_EN adds a saturating dropped-record counter.
module trace_fifo
  import trace_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = REC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iRec_valid,
  input  logic [DW-1:0]          iRec_data,
  output logic                   oRec_ready,
  input  logic                   iLstm_done,
  output logic                   oFIFO_valid,
  output logic [DW-1:0]          oFIFO_data,
  output logic [$clog2(DEPTH):0] oCount,
  output logic                   oOverflow
`ifdef TRACE_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]            oDrop_cnt
`endif
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(DEPTH);
  localparam logic [AddrW:0] OneCnt  = (AddrW + 1)'(1);

  fsm_state_e state_q, state_d;

  logic [AddrW:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]  rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]  count;
  logic            ready_q, ready_d;
  logic            ovf_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   rd_data;
  logic            push, drop, pop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign push  = iRec_valid & ready_q;
  assign drop  = iRec_valid & ~ready_q;
  assign pop   = (state_q == StIssue);

  assign wr_ptr_d = push ? wr_ptr_q + OneCnt : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + OneCnt : rd_ptr_q;
  assign ready_d  = (wr_ptr_d - rd_ptr_d) != FullCnt;

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q[AddrW-1:0]),
    .wr_data_i (iRec_data),
    .rd_addr_i (rd_ptr_q[AddrW-1:0]),
    .rd_data_o (rd_data)
  );

  // The registered occupancy drives issue decisions, so a push into an empty
  // FIFO issues two cycles later while a done with data waiting issues next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (iLstm_done) begin
          state_d = (count != '0) ? StIssue : StWait;
        end
      end
      StWait: begin
        if (count != '0) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (iLstm_done) begin
          state_d = (count > OneCnt) ? StIssue : StWait;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StWait;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_q | drop;
      if (pop) begin
        data_q <= rd_data;
      end
    end
  end

  assign oRec_ready  = ready_q;
  assign oFIFO_valid = pop;
  assign oFIFO_data  = pop ? rd_data : data_q;
  assign oCount      = count;
  assign oOverflow   = ovf_q;

`ifdef TRACE_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign oDrop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_trace_fifo.sv
// Self-checking bench for trace_fifo: queue-based reference model, directed and random stimulus.
module tb_trace_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          iRec_valid = 1'b0;
  logic [DW-1:0] iRec_data = '0;
  logic          oRec_ready;
  logic          iLstm_done = 1'b0;
  logic          oFIFO_valid;
  logic [DW-1:0] oFIFO_data;
  logic [4:0]    oCount;
  logic          oOverflow;
`ifdef TRACE_FIFO_DROP_CNT_EN
  logic [15:0]   oDrop_cnt;
`endif

  trace_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iRec_valid  (iRec_valid),
    .iRec_data   (iRec_data),
    .oRec_ready  (oRec_ready),
    .iLstm_done  (iLstm_done),
    .oFIFO_valid (oFIFO_valid),
    .oFIFO_data  (oFIFO_data),
    .oCount      (oCount),
    .oOverflow   (oOverflow)
`ifdef TRACE_FIFO_DROP_CNT_EN
    ,
    .oDrop_cnt   (oDrop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue contents, credit, and whether an issue is visible this cycle.
  logic [DW-1:0] m_q[$];
  logic          m_credit = 1'b1;
  logic          m_issue = 1'b0;
  logic [DW-1:0] m_last = '0;
  logic          m_ovf = 1'b0;
  logic [15:0]   m_drops = '0;
  logic          armed = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_q.delete();
        m_credit = 1'b1;
        m_issue  = 1'b0;
        m_last   = '0;
        m_ovf    = 1'b0;
        m_drops  = '0;
        armed    = 1'b1;
      end else if (armed) begin
        int remain;
        logic credit_n;
        logic accept;
        accept = iRec_valid && (m_q.size() < DEPTH);
        if (m_issue && m_q.size() > 0) m_last = m_q.pop_front();
        remain   = m_q.size();
        credit_n = (m_credit && !m_issue) || iLstm_done;
        if (accept) begin
          m_q.push_back(iRec_data);
        end else if (iRec_valid) begin
          m_ovf = 1'b1;
          if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end
        m_issue  = credit_n && (remain > 0);
        m_credit = credit_n;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("cyc_valid", 32'(oFIFO_valid), 32'(m_issue));
        if (m_issue && m_q.size() > 0) check("cyc_data", 32'(oFIFO_data), 32'(m_q[0]));
        else check("cyc_data_hold", 32'(oFIFO_data), 32'(m_last));
        check("cyc_count", 32'(oCount), 32'(m_q.size()));
        check("cyc_ready", 32'(oRec_ready), 32'(m_q.size() < DEPTH));
        check("cyc_overflow", 32'(oOverflow), 32'(m_ovf));
`ifdef TRACE_FIFO_DROP_CNT_EN
        check("cyc_drop_cnt", 32'(oDrop_cnt), 32'(m_drops));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    iRec_valid = 1'b1;
    iRec_data  = d;
    step();
    iRec_valid = 1'b0;
  endtask

  task automatic pulse_done();
    iLstm_done = 1'b1;
    step();
    iLstm_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Leaves the FIFO empty with the credit consumed.
  task automatic burn_credit();
    push(13'h0555);
    step();
    step();
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] head;
    int pv, pd;

    // Reset state and single-record latency.
    do_reset();
    check("rst_count", 32'(oCount), 32'd0);
    check("rst_ready", 32'(oRec_ready), 32'd1);
    check("rst_valid", 32'(oFIFO_valid), 32'd0);
    check("rst_data", 32'(oFIFO_data), 32'd0);
    check("rst_overflow", 32'(oOverflow), 32'd0);
    push(13'h0A2F);
    check("lat_no_issue_yet", 32'(oFIFO_valid), 32'd0);
    step();
    check("lat_valid", 32'(oFIFO_valid), 32'd1);
    check("lat_data", 32'(oFIFO_data), 32'h0A2F);
    step();
    check("lat_count_after", 32'(oCount), 32'd0);
    check("lat_data_held", 32'(oFIFO_data), 32'h0A2F);

    // Two records, one credit; done releases the second next cycle.
    do_reset();
    push(13'h011A);
    push(13'h1DC0);
    check("two_first_valid", 32'(oFIFO_valid), 32'd1);
    check("two_first_data", 32'(oFIFO_data), 32'h011A);
    step();
    step();
    step();
    check("two_waiting_valid", 32'(oFIFO_valid), 32'd0);
    check("two_waiting_count", 32'(oCount), 32'd1);
    pulse_done();
    check("two_second_valid", 32'(oFIFO_valid), 32'd1);
    check("two_second_data", 32'(oFIFO_data), 32'h1DC0);

    // Fill to full with the credit withheld, then overflow.
    do_reset();
    burn_credit();
    for (int i = 0; i < 17; i++) begin
      iRec_valid = 1'b1;
      iRec_data  = DW'(13'h0100 + i);
      step();
      if (i == 14) check("fill_not_full", 32'(oRec_ready), 32'd1);
      if (i == 15) begin
        check("fill_full_ready", 32'(oRec_ready), 32'd0);
        check("fill_no_ovf_yet", 32'(oOverflow), 32'd0);
      end
    end
    iRec_valid = 1'b0;
    check("full_count", 32'(oCount), 32'd16);
    check("full_overflow", 32'(oOverflow), 32'd1);
`ifdef TRACE_FIFO_DROP_CNT_EN
    check("full_drop_cnt", 32'(oDrop_cnt), 32'd1);
`endif

    // Push and done together while full: pop issues, push dropped.
    iRec_valid = 1'b1;
    iRec_data  = 13'h1FFF;
    iLstm_done = 1'b1;
    step();
    iRec_valid = 1'b0;
    iLstm_done = 1'b0;
    check("fullpop_valid", 32'(oFIFO_valid), 32'd1);
    check("fullpop_data", 32'(oFIFO_data), 32'h0100);
    check("fullpop_ready", 32'(oRec_ready), 32'd0);
    step();
    check("fullpop_ready_back", 32'(oRec_ready), 32'd1);
    check("fullpop_count", 32'(oCount), 32'd15);
    push(13'h1ABC);
    for (int i = 1; i < 16; i++) exp_q.push_back(DW'(13'h0100 + i));
    exp_q.push_back(13'h1ABC);
    for (int k = 0; k < 20; k++) begin
      pulse_done();
      head = exp_q.pop_front();
      check("wrap_valid", 32'(oFIFO_valid), 32'd1);
      check("wrap_data", 32'(oFIFO_data), 32'(head));
      step();
      push(DW'(13'h0200 + k));
      exp_q.push_back(DW'(13'h0200 + k));
    end

    // Done while credit is already held is ignored.
    do_reset();
    pulse_done();
    pulse_done();
    push(13'h0ABC);
    push(13'h1DEF);
    check("sat_first_data", 32'(oFIFO_data), 32'h0ABC);
    step();
    step();
    step();
    check("sat_one_issue", 32'(oFIFO_valid), 32'd0);
    check("sat_count", 32'(oCount), 32'd1);
    pulse_done();
    check("sat_second_valid", 32'(oFIFO_valid), 32'd1);
    check("sat_second_data", 32'(oFIFO_data), 32'h1DEF);

    // Reset mid-operation discards contents and pending issue.
    do_reset();
    burn_credit();
    for (int i = 0; i < 5; i++) push(DW'(13'h0300 + i));
    check("midrst_count_before", 32'(oCount), 32'd5);
    iLstm_done = 1'b1;
    do_reset();
    iLstm_done = 1'b0;
    check("midrst_count", 32'(oCount), 32'd0);
    check("midrst_valid", 32'(oFIFO_valid), 32'd0);
    step();
    check("midrst_no_pulse", 32'(oFIFO_valid), 32'd0);
    push(13'h0777);
    step();
    check("midrst_reissue_valid", 32'(oFIFO_valid), 32'd1);
    check("midrst_reissue_data", 32'(oFIFO_data), 32'h0777);

    // Random traffic across several push/done rate mixes.
    for (int ph = 0; ph < 4; ph++) begin
      pv = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 50 : 95;
      pd = (ph == 0) ? 50 : (ph == 1) ? 10 : (ph == 2) ? 40 : 5;
      for (int c = 0; c < 800; c++) begin
        iRec_valid = ($urandom_range(0, 99) < pv);
        iRec_data  = DW'($urandom);
        iLstm_done = ($urandom_range(0, 99) < pd);
        reset      = ($urandom_range(0, 999) < 3);
        step();
      end
    end
    iRec_valid = 1'b0;
    iLstm_done = 1'b0;
    reset      = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
